// File: rtl/spi_slave_if_if.sv
`default_nettype none
// =============================================================================
// spi_slave_if_if : signal bundle between an SPI responder and its host logic.
// Optional MISO_OE member under SPI_SLAVE_MISO_OE_EN.          Revision 1.0
// =============================================================================
interface spi_slave_if_if #(
    parameter int WordLen = 8
);
    logic               SCLK;
    logic               CSn;
    logic               MOSI;
    logic               MISO;
    logic               CPOL;
    logic               CPHA;
    logic               BitOrder;
    logic [WordLen-1:0] TxData;
    logic               TxLoad;
    logic               TxReady;
    logic [WordLen-1:0] RxData;
    logic               RxValid;
    logic               TxUnderrun;
    logic               Busy;
`ifdef SPI_SLAVE_MISO_OE_EN
    logic               MISO_OE;
`endif

    modport slave (
`ifdef SPI_SLAVE_MISO_OE_EN
        output MISO_OE,
`endif
        input  SCLK, CSn, MOSI, CPOL, CPHA, BitOrder, TxData, TxLoad,
        output MISO, TxReady, RxData, RxValid, TxUnderrun, Busy
    );

    modport master (
`ifdef SPI_SLAVE_MISO_OE_EN
        input  MISO_OE,
`endif
        output SCLK, CSn, MOSI, CPOL, CPHA, BitOrder, TxData, TxLoad,
        input  MISO, TxReady, RxData, RxValid, TxUnderrun, Busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// =============================================================================
// spi_slave_if : oversampling SPI responder with a single-entry TX buffer.
// Optional MISO_OE output under macro SPI_SLAVE_MISO_OE_EN.    Revision 1.0
// =============================================================================
module spi_slave_if #(
    parameter int WordLen    = 8,
    parameter int SyncStages = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_slave_if_if.slave bus
);
    localparam int               CNT_W    = $clog2(WordLen);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WordLen - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [SyncStages-1:0] sclk_sync_q;
    logic [SyncStages-1:0] csn_sync_q;
    logic [SyncStages-1:0] mosi_sync_q;
    logic                  sclk_d1_q;
    logic                  csn_d1_q;

    state_t                state_q;
    logic                  cpol_q;
    logic                  cpha_q;
    logic                  lsb_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  word_done_q;
    logic [WordLen-1:0]    rx_q;
    logic [WordLen-1:0]    tx_q;
    logic [WordLen-1:0]    buf_q;
    logic                  buf_valid_q;
    logic [WordLen-1:0]    rx_data_q;
    logic                  rx_valid_q;
    logic                  underrun_q;
    logic                  miso_q;
    logic                  busy_q;

    // Synchronizers carry no reset so that a reset never fabricates a CSn edge.
    always_ff @(posedge clk) begin
        sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], bus.SCLK};
        csn_sync_q  <= {csn_sync_q[SyncStages-2:0], bus.CSn};
        mosi_sync_q <= {mosi_sync_q[SyncStages-2:0], bus.MOSI};
        sclk_d1_q   <= sclk_sync_q[SyncStages-1];
        csn_d1_q    <= csn_sync_q[SyncStages-1];
    end

    logic               w_sclk_s;
    logic               w_csn_s;
    logic               w_mosi_s;
    logic               w_sclk_rise;
    logic               w_sclk_fall;
    logic               w_cs_fall;
    logic               w_cs_rise;
    logic               w_lead;
    logic               w_trail;
    logic               w_in_word;
    logic               w_sample;
    logic               w_shift;
    logic               w_load;
    logic               w_order;
    logic               w_active_d;
    logic [WordLen-1:0] w_tx_d;
    logic [WordLen-1:0] w_rx_d;

    always_comb begin
        w_sclk_s    = sclk_sync_q[SyncStages-1];
        w_csn_s     = csn_sync_q[SyncStages-1];
        w_mosi_s    = mosi_sync_q[SyncStages-1];
        w_sclk_rise = w_sclk_s & ~sclk_d1_q;
        w_sclk_fall = ~w_sclk_s & sclk_d1_q;
        w_cs_fall   = csn_d1_q & ~w_csn_s;
        w_cs_rise   = ~csn_d1_q & w_csn_s;

        w_lead      = cpol_q ? w_sclk_fall : w_sclk_rise;
        w_trail     = cpol_q ? w_sclk_rise : w_sclk_fall;
        w_in_word   = (state_q == ACTIVE) && !w_cs_rise;
        w_sample    = w_in_word && (cpha_q ? w_trail : w_lead);
        w_shift     = w_in_word && (cpha_q ? w_lead : w_trail);
        w_active_d  = (state_q == IDLE) ? w_cs_fall : !w_cs_rise;

        // CPHA=0 presents the first bit before any clock, so CSn fall is a load point.
        w_load = ((state_q == IDLE) && w_cs_fall && !bus.CPHA) ||
                 (w_shift && (cpha_q ? (cnt_q == '0) : word_done_q));

        w_order = (state_q == IDLE) ? bus.BitOrder : lsb_q;

        w_tx_d = tx_q;
        if (w_load) begin
            w_tx_d = buf_valid_q ? buf_q : '0;
        end else if (w_shift) begin
            w_tx_d = lsb_q ? {1'b0, tx_q[WordLen-1:1]} : {tx_q[WordLen-2:0], 1'b0};
        end else if ((state_q == ACTIVE) && w_cs_rise) begin
            w_tx_d = '0;
        end

        w_rx_d = lsb_q ? {w_mosi_s, rx_q[WordLen-1:1]} : {rx_q[WordLen-2:0], w_mosi_s};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            cnt_q       <= '0;
            word_done_q <= 1'b0;
            rx_q        <= '0;
            tx_q        <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= w_load && !buf_valid_q;
            tx_q       <= w_tx_d;
            miso_q     <= w_active_d && (w_order ? w_tx_d[0] : w_tx_d[WordLen-1]);
            busy_q     <= w_active_d;

            // A load point drains the buffer first; a same-cycle TxLoad then refills it.
            if (w_load) begin
                buf_valid_q <= 1'b0;
            end
            if (bus.TxLoad && !buf_valid_q) begin
                buf_valid_q <= 1'b1;
                buf_q       <= bus.TxData;
            end

            case (state_q)
                IDLE: begin
                    if (w_cs_fall) begin
                        cpol_q      <= bus.CPOL;
                        cpha_q      <= bus.CPHA;
                        lsb_q       <= bus.BitOrder;
                        cnt_q       <= '0;
                        word_done_q <= 1'b0;
                        state_q     <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (w_cs_rise) begin
                        cnt_q       <= '0;
                        word_done_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        if (w_shift) begin
                            word_done_q <= 1'b0;
                        end
                        if (w_sample) begin
                            rx_q <= w_rx_d;
                            if (cnt_q == LAST_BIT) begin
                                cnt_q       <= '0;
                                rx_data_q   <= w_rx_d;
                                rx_valid_q  <= 1'b1;
                                word_done_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.MISO       = miso_q;
    assign bus.TxReady    = ~buf_valid_q;
    assign bus.RxData     = rx_data_q;
    assign bus.RxValid    = rx_valid_q;
    assign bus.TxUnderrun = underrun_q;
    assign bus.Busy       = busy_q;
`ifdef SPI_SLAVE_MISO_OE_EN
    assign bus.MISO_OE    = busy_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// =============================================================================
// tb_spi_slave_if : bit-level SPI master driving spi_slave_if, checked against
// word-level expectations derived from the load-point rules.   Revision 1.0
// =============================================================================
module tb_spi_slave_if;
    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int HALF = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_if_if #(.WordLen(W)) bus ();

    spi_slave_if #(.WordLen(W), .SyncStages(SYNC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int           n_checks = 0;
    int           n_pass   = 0;
    string        phase    = "init";
    logic [W-1:0] rxq[$];
    int           underruns = 0;
    logic [W-1:0] mosi_w[4];
    logic [W-1:0] miso_w[4];
    logic [W-1:0] tx_w[4];
    logic [W-1:0] last_rx = '0;
    int           ready_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s %s: got 0x%0h expected 0x%0h", phase, tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (bus.RxValid === 1'b1) rxq.push_back(bus.RxData);
        if (bus.TxUnderrun === 1'b1) underruns++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic half_wait();
        repeat (HALF) @(posedge clk);
        #3;
    endtask

    task automatic load_word(input logic [W-1:0] w);
        @(posedge clk);
        #1;
        bus.TxData = w;
        bus.TxLoad = 1'b1;
        @(posedge clk);
        #1;
        bus.TxLoad = 1'b0;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (bus.TxReady !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("tx_ready_wait", (t < 5000), 1);
    endtask

    // One CSn frame of nbits master clocks; MISO captured at each master sample instant.
    task automatic spi_xfer(input logic cpol, input logic cpha, input logic lsb,
                            input int nbits, input bit raise_cs);
        int wi;
        int bi;
        bus.CPOL     = cpol;
        bus.CPHA     = cpha;
        bus.BitOrder = lsb;
        bus.SCLK     = cpol;
        half_wait();
        bus.CSn   = 1'b0;
        ready_cyc = -1;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge clk);
            if (ready_cyc < 0 && bus.TxReady === 1'b1) ready_cyc = i;
        end
        @(posedge clk);
        #3;
        for (int k = 0; k < 4; k++) miso_w[k] = '0;
        for (int n = 0; n < nbits; n++) begin
            wi = n / W;
            bi = lsb ? (n % W) : (W - 1 - (n % W));
            if (!cpha) begin
                bus.MOSI = mosi_w[wi][bi];
                half_wait();
                bus.SCLK = ~cpol;
                miso_w[wi][bi] = bus.MISO;
                half_wait();
                bus.SCLK = cpol;
            end else begin
                bus.SCLK = ~cpol;
                bus.MOSI = mosi_w[wi][bi];
                half_wait();
                bus.SCLK = cpol;
                miso_w[wi][bi] = bus.MISO;
                half_wait();
            end
        end
        half_wait();
        if (raise_cs) begin
            bus.CSn = 1'b1;
            half_wait();
            half_wait();
        end
    endtask

    task automatic run_xfer(input logic cpol, input logic cpha, input logic lsb,
                            input int nbits, input bit raise_cs, input int nsup);
        if (nsup > 0) load_word(tx_w[0]);
        fork
            spi_xfer(cpol, cpha, lsb, nbits, raise_cs);
            begin
                for (int i = 1; i < nsup; i++) begin
                    wait_ready();
                    load_word(tx_w[i]);
                end
            end
        join
    endtask

    // Word i on MISO is the i-th supplied word, else zero; load points number
    // nwords (CPHA=1) or nwords+1 (CPHA=0), each unsupplied one is an underrun.
    task automatic full_test(input logic cpol, input logic cpha, input logic lsb,
                             input int nwords, input int nsup);
        int           rx0;
        int           ur0;
        int           lp;
        logic [W-1:0] exp_m;
        logic [W-1:0] got_r;
        rx0 = rxq.size();
        ur0 = underruns;
        run_xfer(cpol, cpha, lsb, nwords * W, 1'b1, nsup);
        for (int k = 0; k < nwords; k++) begin
            exp_m = (k < nsup) ? tx_w[k] : '0;
            got_r = (rxq.size() > rx0 + k) ? rxq[rx0 + k] : 'x;
            check($sformatf("miso_word%0d", k), miso_w[k], exp_m);
            check($sformatf("rx_word%0d", k), got_r, mosi_w[k]);
        end
        lp = cpha ? nwords : nwords + 1;
        check("rx_valid_count", rxq.size() - rx0, nwords);
        check("underrun_count", underruns - ur0, lp - nsup);
        check("busy_after", bus.Busy, 0);
        check("tx_ready_after", bus.TxReady, 1);
        last_rx = mosi_w[nwords - 1];
        check("rx_data_hold", bus.RxData, last_rx);
    endtask

    task automatic check_reset_values();
        check("rst_miso", bus.MISO, 0);
        check("rst_tx_ready", bus.TxReady, 1);
        check("rst_rx_data", bus.RxData, 0);
        check("rst_rx_valid", bus.RxValid, 0);
        check("rst_underrun", bus.TxUnderrun, 0);
        check("rst_busy", bus.Busy, 0);
    endtask

    initial begin
        int rx0;
        int ur0;
        int nw;
        int ns;
        bus.SCLK = 1'b0; bus.CSn = 1'b1; bus.MOSI = 1'b0;
        bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.BitOrder = 1'b0;
        bus.TxData = '0; bus.TxLoad = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        phase = "reset";
        check_reset_values();
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);

        phase = "t1_mode0_msb";
        tx_w[0] = 8'hA5; mosi_w[0] = 8'h3C;
        full_test(1'b0, 1'b0, 1'b0, 1, 1);
        check("ready_latency_ok", (ready_cyc > 0 && ready_cyc <= SYNC + 2), 1);

        phase = "t2_mode3_lsb";
        tx_w[0] = 8'h81; mosi_w[0] = 8'h5A;
        full_test(1'b1, 1'b1, 1'b1, 1, 1);

        phase = "t3_back_to_back";
        tx_w[0] = 8'h11; tx_w[1] = 8'h22; mosi_w[0] = 8'hF0; mosi_w[1] = 8'h0F;
        full_test(1'b0, 1'b0, 1'b0, 2, 2);

        phase = "t4_underrun";
        mosi_w[0] = 8'($urandom);
        full_test(1'b0, 1'b1, 1'b0, 1, 0);

        phase = "t5_abort";
        tx_w[0] = 8'($urandom); mosi_w[0] = 8'($urandom);
        rx0 = rxq.size();
        ur0 = underruns;
        run_xfer(1'b0, 1'b0, 1'b0, 3, 1'b1, 1);
        check("abort_rx_valid", rxq.size() - rx0, 0);
        check("abort_busy", bus.Busy, 0);
        check("abort_rx_data", bus.RxData, last_rx);
        check("abort_underrun", underruns - ur0, 0);
        phase = "t5_after_abort";
        tx_w[0] = 8'($urandom); mosi_w[0] = 8'($urandom);
        full_test(1'b0, 1'b0, 1'b0, 1, 1);

        phase = "t6_reset_mid_word";
        tx_w[0] = 8'($urandom); mosi_w[0] = 8'($urandom);
        rx0 = rxq.size();
        run_xfer(1'b0, 1'b0, 1'b1, 3, 1'b0, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_values();
        last_rx = '0;
        half_wait();
        half_wait();
        check("busy_held_low_cs", bus.Busy, 0);
        bus.CSn = 1'b1;
        half_wait();
        check("no_rx_after_reset", rxq.size() - rx0, 0);
        phase = "t6_after_reset";
        tx_w[0] = 8'($urandom); mosi_w[0] = 8'($urandom);
        full_test(1'b0, 1'b0, 1'b1, 1, 1);

        for (int it = 0; it < 6; it++) begin
            phase = $sformatf("rand%0d", it);
            nw = 1 + int'($urandom_range(2, 0));
            ns = int'($urandom_range(nw, 0));
            for (int k = 0; k < 4; k++) begin
                tx_w[k]   = 8'($urandom);
                mosi_w[k] = 8'($urandom);
            end
            full_test(1'($urandom), 1'($urandom), 1'($urandom), nw, ns);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
